// File: rtl/rv_sdram_bridge_pkg.sv
// Shared types and constants for the RISC-V to SDRAM-arbiter bridge.
package rv_sdram_bridge_pkg;

  localparam int          RV_ADDR_WIDTH    = 23;
  localparam logic [31:0] RV_TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO_WAIT = 2'd1,
    HI_WAIT = 2'd2,
    DONE    = 2'd3
  } bridge_state_e;

  // Writes drive their own strobes; reads fetch the full halfword.
  function automatic logic [1:0] half_ds(input logic is_wr, input logic [1:0] strb);
    return is_wr ? strb : 2'b11;
  endfunction

endpackage

// File: rtl/rv_ack_watchdog.sv
// Acknowledge watchdog for the bridge, built only with RV_TIMEOUT_EN.
// Restarts on every request toggle, saturates at expiry while a request is pending.
module rv_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_kick,
  input  logic i_pending,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_expired = i_pending && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_kick)                       cnt_d = '0;
    else if (i_pending && !o_expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rv_sdram_bridge.sv
// 32-bit valid/ready CPU bus to 16-bit toggle req/ack arbiter port, split into two halves.
// Define RV_TIMEOUT_EN to add an ack watchdog that completes a stuck access with all-ones data.
module rv_sdram_bridge
  import rv_sdram_bridge_pkg::*;
#(
  parameter int ADDR_W         = RV_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_valid,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  input  logic [3:0]        i_mem_wstrb,
  output logic              o_mem_ready,
  output logic [31:0]       o_mem_rdata,
  output logic [ADDR_W-1:0] o_rv_addr,
  output logic              o_rv_word,
  output logic [31:0]       o_rv_wdata,
  output logic [1:0]        o_rv_ds,
  output logic [3:0]        o_rv_wstrb,
  output logic              o_rv_req,
  input  logic              i_rv_req_ack,
  input  logic [15:0]       i_rv_dout,
  output logic              o_timeout
);

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              word_q, word_d;
  logic [1:0]        ds_q, ds_d;
  logic [3:0]        rvws_q, rvws_d;
  logic              ack_match, is_wr_q;

  assign ack_match = (req_q == i_rv_req_ack);
  assign is_wr_q   = |wstrb_q;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_mem_addr[1:0];

`ifdef RV_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_expired;

  rv_ack_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_kick    (req_d != req_q),
    .i_pending (req_q != i_rv_req_ack),
    .o_expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      req_q   <= i_rv_req_ack;  // no spurious request out of reset
      word_q  <= 1'b0;
      ds_q    <= '0;
      rvws_q  <= '0;
`ifdef RV_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      word_q  <= word_d;
      ds_q    <= ds_d;
      rvws_q  <= rvws_d;
`ifdef RV_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    word_d  = word_q;
    ds_d    = ds_q;
    rvws_d  = rvws_q;
`ifdef RV_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_mem_valid) begin
          addr_d  = i_mem_addr[ADDR_W-1:2];
          wdata_d = i_mem_wdata;
          wstrb_d = i_mem_wstrb;
          rdata_d = '0;
          req_d   = ~req_q;
          // A write touching only the upper half skips the low request entirely.
          if (i_mem_wstrb != 4'b0000 && i_mem_wstrb[1:0] == 2'b00) begin
            word_d  = 1'b1;
            ds_d    = i_mem_wstrb[3:2];
            rvws_d  = {i_mem_wstrb[3:2], 2'b00};
            state_d = HI_WAIT;
          end else begin
            word_d  = 1'b0;
            ds_d    = half_ds(|i_mem_wstrb, i_mem_wstrb[1:0]);
            rvws_d  = {2'b00, i_mem_wstrb[1:0]};
            state_d = LO_WAIT;
          end
        end
      end
      LO_WAIT: begin
        if (ack_match) begin
          if (!is_wr_q) rdata_d[15:0] = i_rv_dout;
          if (!is_wr_q || wstrb_q[3:2] != 2'b00) begin
            req_d   = ~req_q;
            word_d  = 1'b1;
            ds_d    = half_ds(is_wr_q, wstrb_q[3:2]);
            rvws_d  = {wstrb_q[3:2], 2'b00};
            state_d = HI_WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      HI_WAIT: begin
        if (ack_match) begin
          if (!is_wr_q) rdata_d[31:16] = i_rv_dout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef RV_TIMEOUT_EN
    // Withdraw the stuck request and complete the CPU access with poison data.
    if (wd_expired && (state_q == LO_WAIT || state_q == HI_WAIT)) begin
      req_d     = i_rv_req_ack;
      rdata_d   = RV_TIMEOUT_RDATA;
      timeout_d = 1'b1;
      state_d   = DONE;
    end
`endif
  end

  always_comb begin
    o_mem_ready = (state_q == DONE);
    o_mem_rdata = rdata_q;
    o_rv_addr   = {addr_q, 2'b00};
    o_rv_word   = word_q;
    o_rv_wdata  = wdata_q;
    o_rv_ds     = ds_q;
    o_rv_wstrb  = rvws_q;
    o_rv_req    = req_q;
`ifdef RV_TIMEOUT_EN
    o_timeout   = timeout_q;
`else
    o_timeout   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Directed bench for rv_sdram_bridge: scoreboarded arbiter responder plus CPU-side access sequence.
module tb_rv_sdram_bridge;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_mem_valid = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [31:0]   i_mem_wdata = '0;
  logic [3:0]    i_mem_wstrb = '0;
  logic          o_mem_ready;
  logic [31:0]   o_mem_rdata;
  logic [AW-1:0] o_rv_addr;
  logic          o_rv_word;
  logic [31:0]   o_rv_wdata;
  logic [1:0]    o_rv_ds;
  logic [3:0]    o_rv_wstrb;
  logic          o_rv_req;
  logic          ack = 1'b1;
  logic [15:0]   i_rv_dout = '0;
  logic          o_timeout;

  always #5 clk = ~clk;

  rv_sdram_bridge #(
    .ADDR_W(AW)
`ifdef RV_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_mem_valid  (i_mem_valid),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_mem_wstrb  (i_mem_wstrb),
    .o_mem_ready  (o_mem_ready),
    .o_mem_rdata  (o_mem_rdata),
    .o_rv_addr    (o_rv_addr),
    .o_rv_word    (o_rv_word),
    .o_rv_wdata   (o_rv_wdata),
    .o_rv_ds      (o_rv_ds),
    .o_rv_wstrb   (o_rv_wstrb),
    .o_rv_req     (o_rv_req),
    .i_rv_req_ack (ack),
    .i_rv_dout    (i_rv_dout),
    .o_timeout    (o_timeout)
  );

  typedef struct packed {
    logic          word;
    logic [1:0]    ds;
    logic [3:0]    ws;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } rvreq_t;

  rvreq_t      exp_req_q[$];
  logic [15:0] dout_q[$];
  logic [31:0] exp_rd_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_delay = 1;
  bit          hang = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic w, input logic [1:0] ds, input logic [3:0] ws,
                          input logic [AW-1:0] a, input logic [31:0] wd);
    rvreq_t r;
    r.word = w; r.ds = ds; r.ws = ws; r.addr = a; r.wd = wd;
    exp_req_q.push_back(r);
  endtask

  // Drive one CPU access from a negedge; latency counts cycles until ready is seen.
  task automatic do_access(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int exp_lat, input logic [31:0] exp_rd);
    int  lat;
    bit  got;
    exp_rd_q.push_back(exp_rd);
    i_mem_addr = a; i_mem_wdata = wd; i_mem_wstrb = ws; i_mem_valid = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (o_mem_ready) got = 1'b1;
    end
    i_mem_valid = 1'b0;
    chk("ready_seen", 64'(got), 64'd1);
    if (got) begin
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("rdata", 64'(o_mem_rdata), 64'(exp_rd_q.pop_front()));
    end
    @(negedge clk);
    chk("ready_single_pulse", 64'(o_mem_ready), 64'd0);
  endtask

  // Arbiter model: checks each new request against the scoreboard, acks after ack_delay cycles.
  initial begin
    int     cnt;
    logic   pend_req;
    rvreq_t obs;
    cnt = 0; pend_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
      end else if (o_rv_req !== ack) begin
        if (cnt == 0) begin
          pend_req = o_rv_req;
          obs = {o_rv_word, o_rv_ds, o_rv_wstrb, o_rv_addr, o_rv_wdata};
          chk("rvreq_expected", 64'(exp_req_q.size() > 0), 64'd1);
          if (exp_req_q.size() > 0) chk("rvreq_fields", 64'(obs), 64'(exp_req_q.pop_front()));
        end else if (!hang) begin
          chk("req_stable", 64'(o_rv_req), 64'(pend_req));
        end
        cnt++;
        if (!hang && cnt >= ack_delay + 1) begin
          ack = o_rv_req;
          if (dout_q.size() > 0) i_rv_dout = dout_q.pop_front();
          else                   i_rv_dout = 16'h0000;
          cnt = 0;
        end
      end else begin
        if (cnt > 0 && !hang) chk("req_stable", 64'(o_rv_req), 64'(pend_req));
        cnt = 0;
      end
    end
  end

  // valid must stay high until the bridge has returned ready
  logic vprev = 1'b0;
  always @(posedge clk) begin
    if (vprev && !rst) chk("valid_held", 64'(i_mem_valid | o_mem_ready), 64'd1);
    vprev <= i_mem_valid;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  n;
    bit  reached;

    repeat (3) @(negedge clk);
    chk("rst_req_eq_ack", 64'(o_rv_req), 64'(ack));
    chk("rst_ready",   64'(o_mem_ready), 64'd0);
    chk("rst_rdata",   64'(o_mem_rdata), 64'd0);
    chk("rst_addr",    64'(o_rv_addr),   64'd0);
    chk("rst_word",    64'(o_rv_word),   64'd0);
    chk("rst_wdata",   64'(o_rv_wdata),  64'd0);
    chk("rst_ds",      64'(o_rv_ds),     64'd0);
    chk("rst_wstrb",   64'(o_rv_wstrb),  64'd0);
    chk("rst_timeout", 64'(o_timeout),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // read in WRAM range, two halves
    push_req(1'b0, 2'b11, 4'b0000, 23'h066004, 32'h0);
    push_req(1'b1, 2'b11, 4'b0000, 23'h066004, 32'h0);
    dout_q.push_back(16'h1234); dout_q.push_back(16'hABCD);
    do_access(23'h066004, 32'h0, 4'b0000, 5, 32'hABCD1234);

    // full-word write
    push_req(1'b0, 2'b11, 4'b0011, 23'h000100, 32'hDEADBEEF);
    push_req(1'b1, 2'b11, 4'b1100, 23'h000100, 32'hDEADBEEF);
    do_access(23'h000100, 32'hDEADBEEF, 4'b1111, 5, 32'h0);

    // upper-byte-only write, unaligned address bits dropped
    push_req(1'b1, 2'b10, 4'b1000, 23'h000200, 32'h11223344);
    do_access(23'h000203, 32'h11223344, 4'b1000, 3, 32'h0);

    // lower-byte-only write
    push_req(1'b0, 2'b01, 4'b0001, 23'h000300, 32'h55667788);
    do_access(23'h000300, 32'h55667788, 4'b0001, 3, 32'h0);

    // middle bytes straddle both halves
    push_req(1'b0, 2'b10, 4'b0010, 23'h000304, 32'h99AABBCC);
    push_req(1'b1, 2'b01, 4'b0100, 23'h000304, 32'h99AABBCC);
    do_access(23'h000304, 32'h99AABBCC, 4'b0110, 5, 32'h0);

    // slow arbiter: 20-cycle ack per half
    ack_delay = 20;
    push_req(1'b0, 2'b11, 4'b0000, 23'h000500, 32'h0);
    push_req(1'b1, 2'b11, 4'b0000, 23'h000500, 32'h0);
    dout_q.push_back(16'hCAFE); dout_q.push_back(16'hF00D);
    do_access(23'h000500, 32'h0, 4'b0000, 43, 32'hF00DCAFE);

    // reset while the high half is outstanding
    ack_delay = 3;
    push_req(1'b0, 2'b11, 4'b0000, 23'h000400, 32'h0);
    push_req(1'b1, 2'b11, 4'b0000, 23'h000400, 32'h0);
    dout_q.push_back(16'h5555);
    i_mem_addr = 23'h000400; i_mem_wdata = 32'h0; i_mem_wstrb = 4'b0000; i_mem_valid = 1'b1;
    reached = 1'b0; n = 0;
    while (!reached && n < 50) begin
      @(negedge clk);
      n++;
      if (o_rv_word === 1'b1 && o_rv_req !== ack) reached = 1'b1;
    end
    chk("hi_wait_reached", 64'(reached), 64'd1);
    @(negedge clk);
    rst = 1'b1; i_mem_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_ready_in_reset", 64'(o_mem_ready), 64'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_ready_after_reset", 64'(o_mem_ready), 64'd0);
    end
    chk("req_eq_ack_after_reset", 64'(o_rv_req), 64'(ack));

    ack_delay = 1;
    push_req(1'b0, 2'b11, 4'b0000, 23'h066008, 32'h0);
    push_req(1'b1, 2'b11, 4'b0000, 23'h066008, 32'h0);
    dout_q.push_back(16'h1111); dout_q.push_back(16'h2222);
    do_access(23'h066008, 32'h0, 4'b0000, 5, 32'h22221111);

`ifdef RV_TIMEOUT_EN
    hang = 1'b1;
    push_req(1'b0, 2'b11, 4'b0000, 23'h000700, 32'h0);
    do_access(23'h000700, 32'h0, 4'b0000, 17, 32'hFFFFFFFF);
    chk("timeout_set", 64'(o_timeout), 64'd1);
    chk("timeout_req_eq_ack", 64'(o_rv_req), 64'(ack));
    repeat (3) @(negedge clk);
    hang = 1'b0;
    push_req(1'b0, 2'b11, 4'b0000, 23'h000704, 32'h0);
    push_req(1'b1, 2'b11, 4'b0000, 23'h000704, 32'h0);
    dout_q.push_back(16'h3333); dout_q.push_back(16'h4444);
    do_access(23'h000704, 32'h0, 4'b0000, 5, 32'h44443333);
    chk("timeout_sticky", 64'(o_timeout), 64'd1);
`else
    chk("timeout_tied_low", 64'(o_timeout), 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("all_requests_seen", 64'(exp_req_q.size()), 64'd0);
    chk("all_dout_consumed", 64'(dout_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_sdram_bridge.md
Name: rv_sdram_bridge

Overview:
- Sits directly upstream of the SDRAM arbiter's RISC-V port.
- Converts the IOSys softcore's 32-bit valid/ready memory bus into the arbiter's 16-bit toggle request/acknowledge transactions.
- Splits each 32-bit access into low and high halfword requests and reassembles read data.
- Drops halfword writes that have no byte strobes.

Parameters:
- ADDR_W, 23, RISC-V byte address width; matches the arbiter's rv address input.
- TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with RV_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock, the single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_mem_valid  in  1  CPU request; held high until o_mem_ready.
- i_mem_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- i_mem_wdata  in  32  write data.
- i_mem_wstrb  in  4  byte strobes; 0 means read.
- o_mem_ready  out  1  one-cycle completion pulse.
- o_mem_rdata  out  32  read data; valid while o_mem_ready=1.
- o_rv_addr  out  ADDR_W  to arbiter i_rv_addr; word-aligned.
- o_rv_word  out  1  halfword select: 0 = low half, 1 = high half.
- o_rv_wdata  out  32  to arbiter i_rv_wdata.
- o_rv_ds  out  2  halfword byte enables.
- o_rv_wstrb  out  4  strobes of the current half only (others 0); 0 for reads.
- o_rv_req  out  1  toggle request.
- i_rv_req_ack  in  1  toggle acknowledge from the arbiter.
- i_rv_dout  in  16  halfword read data; valid when ack equals req.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Handshake rules:
  - A request is pending while o_rv_req != i_rv_req_ack.
  - It completes on the first cycle they are equal.
  - Never toggle o_rv_req while a request is pending.
- FSM states: IDLE, LO_WAIT, HI_WAIT, DONE.
- IDLE:
  - On i_mem_valid, register addr/wdata/wstrb.
  - Write with wstrb[1:0]==0: go directly to issuing the high half.
  - Otherwise: toggle o_rv_req with o_rv_word=0, o_rv_ds=wstrb[1:0] (reads: 2'b11), o_rv_wstrb={2'b00,wstrb[1:0]}, then go to LO_WAIT.
- LO_WAIT:
  - On ack match, capture i_rv_dout into rdata[15:0].
  - If read, or write with wstrb[3:2]!=0: toggle o_rv_req with o_rv_word=1, o_rv_ds=wstrb[3:2] (reads 2'b11), o_rv_wstrb={wstrb[3:2],2'b00}, go to HI_WAIT.
  - Otherwise go to DONE.
- HI_WAIT: on ack match, capture rdata[31:16]; go to DONE.
- DONE: o_mem_ready=1 for exactly one cycle; return to IDLE. The next request is accepted no earlier than the following cycle.
- Writes: o_mem_rdata=0.
- Minimum latency, given an ack that arrives 1 cycle after the toggle:
  - Read: 5 cycles from valid to ready.
  - Single-half write: 3 cycles.
- o_rv_addr = {registered addr[ADDR_W-1:2], 2'b00}. o_rv_wdata carries the full registered word; the arbiter selects the half via o_rv_word.
- A write with wstrb==0 is impossible by definition; a write with strobes only in one half issues exactly one request.
- Reset:
  - o_rv_req <= i_rv_req_ack, so no spurious request is issued.
  - All other outputs reset to 0; state goes to IDLE.
  - Reset mid-transaction abandons the transaction without a ready pulse. The arbiter is reset in the same domain.
- i_mem_valid dropping before ready is illegal; a bench assertion flags it.
- WRAM addresses (0x66000–0x68000) get no special handling here; routing is the arbiter's responsibility.

Optional Feature:
- Macro: RV_TIMEOUT_EN.
- When defined:
  - A counter resets on each toggle and increments while a request is pending.
  - At TIMEOUT_CYCLES the FSM forces o_rv_req <= i_rv_req_ack, goes to DONE, returns o_mem_rdata=32'hFFFF_FFFF and sets o_timeout.
  - o_timeout is cleared only by reset.
- When undefined: no counter; o_timeout is tied to 0; waits are unbounded.

Decomposition:
- configPackage:
  - RV_ADDR_WIDTH=23.
  - Bridge state typedef (IDLE, LO_WAIT, HI_WAIT, DONE).
  - RV_TIMEOUT_RDATA=32'hFFFF_FFFF.
- No sub-module for the core path; FSM and datapath stay in one module.
- Optional sub-module rv_ack_watchdog holds the RV_TIMEOUT_EN counter.

Test Plan:
- Read addr 0x66004, ack 1 cycle after each toggle, dout 0x1234 then 0xABCD -> two toggles with o_rv_word 0 then 1, o_mem_rdata=0xABCD1234, ready at cycle 5.
- Write 0xDEADBEEF, wstrb=4'b1111 -> two requests: ds 2'b11, o_rv_wstrb 0011 then 1100; one ready pulse.
- Write wstrb=4'b1000 -> single request, o_rv_word=1, o_rv_ds=2'b10; ready 3 cycles after valid.
- Ack delayed 20 cycles -> o_rv_req stable throughout; no ready until the ack matches.
- i_reset asserted during HI_WAIT -> no ready pulse; o_rv_req equals ack afterwards; the next read completes normally.
- With RV_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never toggles -> ready at about 17 cycles, rdata 0xFFFFFFFF, o_timeout=1 and held.
